// File: rtl/sort_kernel_ctrl.sv
// rtl/sort_kernel_ctrl.sv - ap_ctrl_hs kernel sequencer for the per-channel merge trees
//
// Purpose:
//   Accepts a run from the host, latches per-run scalars, derives how many
//   merge passes are needed to turn presorted chunks into one sorted run,
//   pulses a start to every channel and reports completion once all
//   channels have signalled done.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   ap_start                host start level
//   ap_idle                 high while idle
//   ap_ready                one-cycle pulse when scalars are latched
//   ap_done                 one-cycle completion pulse
//   i_ptr                   per-channel buffer base pointers
//   i_xfer_size_in_bytes    per-channel data size in bytes
//   o_ch_start              one-cycle start pulse to all channels
//   o_num_pass              computed merge pass count
//   o_ptr                   latched pointers
//   o_xfer_size_in_bytes    latched size
//   i_ch_done               per-channel done pulses

module sort_kernel_ctrl #(
    parameter int NUM_CHANNELS        = 2,
    parameter int C_M_AXI_ADDR_WIDTH  = 64,
    parameter int C_XFER_SIZE_WIDTH   = 64,
    parameter int C_RECORD_BIT_WIDTH  = 64,
    parameter int C_INIT_SORTED_CHUNK = 16,
    parameter int C_NUM_LEAVES        = 16
) (
    input  logic                                         aclk,
    input  logic                                         areset,
    input  logic                                         ap_start,
    output logic                                         ap_idle,
    output logic                                         ap_ready,
    output logic                                         ap_done,
    input  logic [NUM_CHANNELS*C_M_AXI_ADDR_WIDTH-1:0]   i_ptr,
    input  logic [C_XFER_SIZE_WIDTH-1:0]                 i_xfer_size_in_bytes,
    output logic                                         o_ch_start,
    output logic [7:0]                                   o_num_pass,
    output logic [NUM_CHANNELS*C_M_AXI_ADDR_WIDTH-1:0]   o_ptr,
    output logic [C_XFER_SIZE_WIDTH-1:0]                 o_xfer_size_in_bytes,
    input  logic [NUM_CHANNELS-1:0]                      i_ch_done
);

    localparam int PTR_W      = NUM_CHANNELS * C_M_AXI_ADDR_WIDTH;
    localparam int REC_SHIFT  = $clog2(C_RECORD_BIT_WIDTH / 8);
    localparam int LEAF_SHIFT = $clog2(C_NUM_LEAVES);
    // One extra leaf-shift of headroom: run_len only grows while below a
    // record count that fits in C_XFER_SIZE_WIDTH bits.
    localparam int RUN_W      = C_XFER_SIZE_WIDTH + LEAF_SHIFT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                         state;
    state_t                         state_nxt;

    logic [PTR_W-1:0]               ptr_lat;
    logic [C_XFER_SIZE_WIDTH-1:0]   size_lat;
    logic [C_XFER_SIZE_WIDTH-1:0]   records;
    logic [RUN_W-1:0]               run_len;
    logic [7:0]                     pass;
    logic [NUM_CHANNELS-1:0]        done_sticky;

    logic                           calc_fit;
    logic                           calc_exit;
    logic                           all_done;

    assign calc_fit  = run_len >= {{LEAF_SHIFT{1'b0}}, records};
    // Saturated pass count forces an exit so CALC can never spin forever.
    assign calc_exit = calc_fit || (pass == 8'hFF);
    assign all_done  = &(done_sticky | i_ch_done);

    always_comb begin
        state_nxt  = state;
        ap_idle    = 1'b0;
        ap_ready   = 1'b0;
        ap_done    = 1'b0;
        o_ch_start = 1'b0;
        unique case (state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    ap_ready  = 1'b1;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (calc_fit) begin
                    // Zero passes: data is already one sorted run, skip channels.
                    state_nxt = (pass != 8'd0) ? S_START : S_DONE;
                end else if (pass == 8'hFF) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                o_ch_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (all_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ap_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state                <= S_IDLE;
            ptr_lat              <= '0;
            size_lat             <= '0;
            records              <= '0;
            run_len              <= '0;
            pass                 <= '0;
            done_sticky          <= '0;
            o_num_pass           <= '0;
            o_ptr                <= '0;
            o_xfer_size_in_bytes <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        ptr_lat  <= i_ptr;
                        size_lat <= i_xfer_size_in_bytes;
                        // Partial trailing bytes do not form a record.
                        records  <= i_xfer_size_in_bytes >> REC_SHIFT;
                        run_len  <= RUN_W'(C_INIT_SORTED_CHUNK);
                        pass     <= 8'd0;
                    end
                end
                S_CALC: begin
                    if (calc_exit) begin
                        o_num_pass           <= pass;
                        o_ptr                <= ptr_lat;
                        o_xfer_size_in_bytes <= size_lat;
                    end else begin
                        run_len <= run_len << LEAF_SHIFT;
                        pass    <= pass + 8'd1;
                    end
                end
                S_START: begin
                    // Clearing here drops any stale done pulses from an aborted run.
                    done_sticky <= '0;
                end
                S_WAIT: begin
                    done_sticky <= done_sticky | i_ch_done;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_kernel_ctrl.sv
// tb/tb_sort_kernel_ctrl.sv - scoreboard bench for sort_kernel_ctrl
module tb_sort_kernel_ctrl;

    localparam int NC = 2;
    localparam int AW = 64;
    localparam int XW = 64;
    localparam int PW = NC * AW;

    localparam int EV_READY = 0;
    localparam int EV_START = 1;
    localparam int EV_DONE  = 2;

    typedef struct {
        int          kind;
        int          cyc;
        int          np;
        logic [PW-1:0] ptr;
        logic [XW-1:0] size;
    } ev_t;

    logic            clk;
    logic            areset;
    logic            ap_start;
    logic            ap_idle;
    logic            ap_ready;
    logic            ap_done;
    logic [PW-1:0]   i_ptr;
    logic [XW-1:0]   i_xfer_size_in_bytes;
    logic            o_ch_start;
    logic [7:0]      o_num_pass;
    logic [PW-1:0]   o_ptr;
    logic [XW-1:0]   o_xfer_size_in_bytes;
    logic [NC-1:0]   i_ch_done;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    ev_t exp_q[$];
    bit  prev_hold;

    sort_kernel_ctrl #(
        .NUM_CHANNELS(NC),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_XFER_SIZE_WIDTH(XW),
        .C_RECORD_BIT_WIDTH(64),
        .C_INIT_SORTED_CHUNK(16),
        .C_NUM_LEAVES(16)
    ) dut (
        .aclk(clk),
        .areset(areset),
        .ap_start(ap_start),
        .ap_idle(ap_idle),
        .ap_ready(ap_ready),
        .ap_done(ap_done),
        .i_ptr(i_ptr),
        .i_xfer_size_in_bytes(i_xfer_size_in_bytes),
        .o_ch_start(o_ch_start),
        .o_num_pass(o_num_pass),
        .o_ptr(o_ptr),
        .o_xfer_size_in_bytes(o_xfer_size_in_bytes),
        .i_ch_done(i_ch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Merge passes: each pass multiplies sorted run length by the fan-in.
    function automatic int model_passes(input longint unsigned size);
        longint unsigned recs = size / 8;
        longint unsigned len  = 16;
        int p = 0;
        while (len < recs) begin
            len = len * 16;
            p++;
        end
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input int c, input int np,
                           input logic [PW-1:0] ptr, input logic [XW-1:0] size);
        ev_t e;
        e.kind = kind; e.cyc = c; e.np = np; e.ptr = ptr; e.size = size;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic mon(input int kind);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event actual kind=%0d cycle=%0d required=none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                n_errors++;
                $display("FAIL event_timing actual kind=%0d cycle=%0d required kind=%0d cycle=%0d",
                         kind, cyc, e.kind, e.cyc);
            end
            if (kind != EV_READY) begin
                n_checks++;
                if (32'(o_num_pass) != e.np || o_ptr !== e.ptr || o_xfer_size_in_bytes !== e.size) begin
                    n_errors++;
                    $display("FAIL scalars cycle=%0d actual np=%0d ptr=%0h size=%0h required np=%0d ptr=%0h size=%0h",
                             cyc, o_num_pass, o_ptr, o_xfer_size_in_bytes, e.np, e.ptr, e.size);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (ap_ready)   mon(EV_READY);
        if (o_ch_start) mon(EV_START);
        if (ap_done)    mon(EV_DONE);
    end

    // One host run. Done delays are cycles after the start-pulse cycle.
    task automatic run(input longint unsigned size, input logic [PW-1:0] ptrs,
                       input int d0, input int d1, input bit dup, input bit ign,
                       input bit chained, input bit hold, input int rst_at);
        int t, p, s, c0, c1, dn, stop;
        if (chained) step();
        else begin step(); step(); end
        t = cyc;
        ap_start = 1'b1;
        i_ptr = ptrs;
        i_xfer_size_in_bytes = size;
        p = model_passes(size);
        push_ev(EV_READY, t, 0, '0, '0);
        if (p == 0) begin
            dn = t + 2;
            push_ev(EV_DONE, dn, 0, ptrs, size);
            while (cyc < dn) begin
                step();
                ap_start = hold;
            end
        end else begin
            s  = t + p + 2;
            c0 = s + d0;
            c1 = s + d1;
            dn = ((c0 > c1) ? c0 : c1) + 1;
            push_ev(EV_START, s, p, ptrs, size);
            if (rst_at == 0) push_ev(EV_DONE, dn, p, ptrs, size);
            stop = (rst_at != 0) ? s + rst_at : dn;
            while (cyc < stop) begin
                step();
                ap_start  = hold;
                i_ch_done = '0;
                if (ign && cyc == s)      i_ch_done = '1;
                if (cyc == c0)            i_ch_done[0] = 1'b1;
                if (cyc == c1)            i_ch_done[1] = 1'b1;
                if (dup && cyc == c0 + 1) i_ch_done[0] = 1'b1;
            end
            if (rst_at != 0) begin
                areset = 1'b1;
                i_ch_done = '0;
                step();
                areset = 1'b0;
                ap_start = 1'b0;
                @(negedge clk);
                check("rst_idle", PW'(ap_idle), PW'(1));
                check("rst_num_pass", PW'(o_num_pass), '0);
                check("rst_ptr", o_ptr, '0);
                check("rst_size", PW'(o_xfer_size_in_bytes), '0);
                step();
                i_ch_done = 2'b01;
                step();
                i_ch_done = '0;
            end
        end
    endtask

    initial begin
        logic [PW-1:0] pr;
        longint unsigned sz;
        bit hold;
        areset = 1'b1;
        ap_start = 1'b0;
        i_ptr = '0;
        i_xfer_size_in_bytes = '0;
        i_ch_done = '0;
        repeat (3) step();
        @(negedge clk);
        check("reset_idle", PW'(ap_idle), PW'(1));
        check("reset_pulses", PW'({ap_ready, ap_done, o_ch_start}), '0);
        check("reset_num_pass", PW'(o_num_pass), '0);
        check("reset_ptr", o_ptr, '0);
        check("reset_size", PW'(o_xfer_size_in_bytes), '0);
        step();
        areset = 1'b0;

        pr = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        run(8192, pr, 16, 21, 0, 0, 0, 0, 0);
        run(2048, ~pr, 3, 5, 0, 0, 0, 0, 0);
        run(2056, pr ^ 128'h1, 5, 2, 0, 0, 0, 0, 0);
        run(128, pr + 128'd7, 1, 1, 0, 0, 0, 0, 0);
        run(135, pr + 128'd9, 1, 1, 0, 0, 0, 0, 0);
        run(136, pr + 128'd11, 2, 4, 0, 0, 0, 0, 0);
        run(4096, {64'hA, 64'hB}, 7, 7, 0, 0, 0, 0, 0);
        run(8192, {64'hC, 64'hD}, 3, 10, 1, 0, 0, 0, 0);
        run(1000, {64'hE, 64'hF}, 4, 6, 0, 1, 0, 0, 0);
        run(8192, {64'h10, 64'h20}, 20, 25, 0, 0, 0, 0, 5);
        run(2056, {64'h30, 64'h40}, 6, 3, 0, 0, 0, 0, 0);
        run(8192, {64'h50, 64'h60}, 2, 4, 0, 0, 0, 1, 0);
        run(2048, {64'h70, 64'h80}, 3, 1, 0, 0, 1, 0, 0);

        prev_hold = 1'b0;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0:       sz = $urandom_range(0, 300);
                1:       sz = $urandom_range(0, 4096);
                default: sz = $urandom_range(0, 32'h40_0000);
            endcase
            pr = {$urandom, $urandom, $urandom, $urandom};
            hold = ($urandom_range(0, 3) == 0);
            run(sz, pr, $urandom_range(1, 12), $urandom_range(1, 12),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), prev_hold, hold, 0);
            prev_hold = hold;
        end
        ap_start = 1'b0;

        repeat (40) step();
        check("queue_drained", PW'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sort_kernel_ctrl.md
# sort_kernel_ctrl

Kernel-level sequencer between the AXI4-Lite control register block and the per-channel merge-tree tops. It implements the ap_ctrl_hs handshake toward the host and latches the per-run scalars. It computes the number of merge passes from the transfer size, issues one start pulse to every channel, and raises ap_done once every channel has reported completion.

## Interface
Parameters:
- NUM_CHANNELS, 2, number of merge-tree channels controlled.
- C_M_AXI_ADDR_WIDTH, 64, pointer width.
- C_XFER_SIZE_WIDTH, 64, transfer size width in bytes.
- C_RECORD_BIT_WIDTH, 64, record width in bits; a power of two and at least 8.
- C_INIT_SORTED_CHUNK, 16, records per presorted run in memory; a power of two.
- C_NUM_LEAVES, 16, merge-tree fan-in; a power of two and at least 2.

Ports (one clock; reset is synchronous and active-high):
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- ap_start  in  1  host start level.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse when the scalars are latched.
- ap_done  out  1  one-cycle completion pulse.
- i_ptr  in  NUM_CHANNELS×C_M_AXI_ADDR_WIDTH  per-channel buffer base pointers.
- i_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  per-channel data size.
- o_ch_start  out  1  one-cycle start pulse, fanned out to all channels.
- o_num_pass  out  8  computed pass count.
- o_ptr  out  NUM_CHANNELS×C_M_AXI_ADDR_WIDTH  latched pointers.
- o_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  latched size.
- i_ch_done  in  NUM_CHANNELS  per-channel done pulses.

## Operation
States:
- **IDLE**
  - ap_idle=1.
  - When ap_start=1: pulse ap_ready the same cycle.
  - Latch i_ptr and i_xfer_size_in_bytes.
  - records = size >> log2(C_RECORD_BIT_WIDTH/8); partial trailing bytes are dropped.
  - run_len = C_INIT_SORTED_CHUNK; pass = 0.
  - Next state: CALC.
- **CALC** (one compare per cycle)
  - If run_len ≥ records: go to START when pass>0, or go directly to DONE when pass=0 (data is already one sorted run; channels are not started).
  - Otherwise run_len <<= log2(C_NUM_LEAVES) and pass += 1.
  - run_len is C_XFER_SIZE_WIDTH+log2(C_NUM_LEAVES) bits wide, so it cannot overflow.
  - pass saturates at 255; saturation forces exit to START.
- **START**
  - o_ch_start=1 for exactly one cycle.
  - The done_sticky vector is cleared.
  - i_ch_done arriving in this cycle is ignored.
  - Next state: WAIT.
- **WAIT**
  - done_sticky |= i_ch_done.
  - When (done_sticky | i_ch_done) is all ones, go to DONE.
  - Repeated pulses from the same channel have no further effect.
- **DONE**
  - ap_done=1 for one cycle.
  - Next state: IDLE.

Output stability and start handling:
- o_num_pass, o_ptr and o_xfer_size_in_bytes are registered.
- They update on CALC exit and hold until the next acceptance.
- ap_start is ignored outside IDLE.
- If ap_start is still high on return to IDLE, a new run begins.

## Timing
Reset values:
- State = IDLE.
- ap_idle=1.
- ap_ready, ap_done, o_ch_start = 0.
- o_num_pass=0, o_ptr=0, o_xfer_size_in_bytes=0, done_sticky=0.

Latency and reset behaviour:
- Acceptance cycle T (IDLE, ap_start=1): ap_ready is high combinationally in cycle T; ap_idle is low from T+1.
- CALC occupies num_pass+1 cycles, T+1 … T+num_pass+1.
- o_ch_start is high in cycle T+num_pass+2.
- ap_done is high in the cycle after WAIT observes the final outstanding i_ch_done.
- Zero-pass run: CALC lasts 1 cycle, ap_done is high at T+2, and o_ch_start never asserts.
- Reset mid-run returns to IDLE next cycle with all reset values and no o_ch_start. Channels are not notified; their later done pulses are ignored because done_sticky is cleared in START.

## Test plan
- **Reset:** hold areset for 3 cycles → ap_idle=1, all other outputs 0, o_num_pass=0.
- **Nominal two-pass run:** size 8192 B, 64-bit records (1024 records) → ap_ready at T, o_num_pass=2, o_ch_start only at T+4. Then ch0 done at T+20 and ch1 done at T+25 → ap_done only at T+26.
- **Pass boundaries:** 256 records → o_num_pass=1; 257 records → 2; 16 records → 0, with ap_done at T+2 and no o_ch_start.
- **Done edge cases:** both channels pulse done in the same cycle → single ap_done the next cycle. A duplicate ch0 pulse while ch1 is still outstanding → no early ap_done.
- **Reset mid-run:** assert areset in WAIT → IDLE next cycle. A stale ch0 done pulse arriving during IDLE is ignored. A new start then completes normally with the correct o_num_pass.
- **Back-to-back runs:** ap_start held high across DONE → second acceptance in the cycle after DONE, with fresh scalars latched.
